// File: rtl/regfile_param.sv
// Parameterised multi-port register file that zeroes itself one entry per cycle after reset.
// Optional write-through bypass is selected by defining macro RF_BYPASS_EN.
module regfile_param #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StClear, StIdle} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] ra;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = wr_drop_q;
    if (state_q == StClear) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (we) wr_drop_d = 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = StIdle;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StClear;
      cnt_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage has no reset of its own; the clear walk zeroes it and reads stay masked meanwhile.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) begin
        mem_q[cnt_q] <= '0;
      end else if (we && (waddr != '0)) begin
        mem_q[waddr] <= wdata;
      end
    end
  end

  assign busy    = (state_q == StClear);
  assign wr_drop = wr_drop_q;

  always_comb begin
    rdata = '0;
    ra    = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      if (!busy && (ra != '0)) begin
        rdata[i*DATA_W +: DATA_W] = mem_q[ra];
`ifdef RF_BYPASS_EN
        if (we && (waddr != '0) && (ra == waddr)) rdata[i*DATA_W +: DATA_W] = wdata;
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: table vectors, hand sequences and a random run
// against an array-based reference model; a second small instance covers the 3-port config.
module tb_regfile_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, we, busy, wr_drop;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;

  regfile_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .busy(busy), .wr_drop(wr_drop)
  );

  logic        s_rst, s_we, s_busy, s_wr_drop;
  logic [2:0]  s_waddr;
  logic [15:0] s_wdata;
  logic [8:0]  s_raddr;
  logic [47:0] s_rdata;

  regfile_param #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) dut_s (
    .clk(clk), .rst(s_rst), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .raddr(s_raddr), .rdata(s_rdata), .busy(s_busy), .wr_drop(s_wr_drop)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: clear countdown, sticky drop flag, plain array of contents.
  logic [31:0] mem_m [32];
  int          clr_left = 0;
  logic        drop_m   = 1'b0;
  bit          valid    = 1'b0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a0, a1;
    logic [31:0] e0, e1;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (clr_left > 0 || a == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (we && waddr != 5'd0 && a == waddr) return wdata;
`endif
    return mem_m[a];
  endfunction

  task automatic drive(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd; raddr = {a1, a0};
    #1;
  endtask

  task automatic check_model();
    if (!valid) return;
    chk("busy", 32'(busy), 32'(clr_left > 0));
    chk("wr_drop", 32'(wr_drop), 32'(drop_m));
    chk("rd0", rdata[31:0], exp_rd(raddr[4:0]));
    chk("rd1", rdata[63:32], exp_rd(raddr[9:5]));
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (rst) begin
      clr_left = 32;
      drop_m   = 1'b0;
      valid    = 1'b1;
    end else if (clr_left > 0) begin
      if (we) drop_m = 1'b1;
      clr_left--;
      if (clr_left == 0) for (int a = 0; a < 32; a++) mem_m[a] = 32'h0;
    end else if (we && waddr != 5'd0) begin
      mem_m[waddr] = wdata;
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] a0, input logic [4:0] a1);
    drive(r, w, wa, wd, a0, a1);
    check_model();
    edge_step();
  endtask

  // Counts edges taken while busy is high, bounded so a stuck clear still terminates.
  task automatic count_clear(output int n);
    logic b;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(k), 5'(k + 1));
      check_model();
      b = busy;
      edge_step();
      if (!b) break;
      n++;
    end
  endtask

  initial begin
    int n;
    logic [4:0] wa, a0, a1;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    s_rst = 1'b1; s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_raddr = '0;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0,        32'h0};
    tbl[1] = '{1'b1, 5'd0,  32'h00001234, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    tbl[3] = '{1'b1, 5'd31, 32'h0F0F0F0F, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    tbl[4] = '{1'b0, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd5,  32'h0F0F0F0F, 32'hDEADBEEF};
    tbl[5] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'h0F0F0F0F, 32'h0F0F0F0F};

    // Two reset edges, then a 32-edge clear leaving every register zero.
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd4, 32'h77, 5'd4, 5'd4);
    count_clear(n);
    chk("clear_len", 32'(n), 32'd32);
    for (int a = 0; a < 32; a += 2) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(a + 1));
      check_model();
      chk("zero_after_clear", rdata[31:0] | rdata[63:32], 32'h0);
      edge_step();
    end

    for (int i = 0; i < 6; i++) begin
      drive(1'b0, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].a0, tbl[i].a1);
      check_model();
      chk("tbl_rd0", rdata[31:0], tbl[i].e0);
      chk("tbl_rd1", rdata[63:32], tbl[i].e1);
      chk("tbl_drop", 32'(wr_drop), 32'h0);
      edge_step();
    end

    // Same-cycle read of the register being written.
    drive(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd3);
    check_model();
`ifdef RF_BYPASS_EN
    chk("bypass_rd0", rdata[31:0], 32'hA5A5A5A5);
`else
    chk("no_bypass_rd0", rdata[31:0], 32'h0);
`endif
    edge_step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    check_model();
    chk("after_write7", rdata[63:32], 32'hA5A5A5A5);
    edge_step();

    for (int i = 0; i < 400; i++) begin
      wa = 5'($urandom);
      a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom);
      cyc(($urandom_range(0, 63) == 0), 1'($urandom), wa, $urandom, a0, a1);
    end

    // Write during clear is dropped and flagged; flag is sticky until reset.
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
    cyc(1'b0, 1'b1, 5'd3, 32'h55, 5'd3, 5'd3);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check_model();
    chk("drop_set", 32'(wr_drop), 32'h1);
    edge_step();
    count_clear(n);
    drive(1'b0, 1'b1, 5'd0, 32'h99, 5'd3, 5'd3);
    check_model();
    chk("reg3_zero", rdata[31:0], 32'h0);
    chk("drop_sticky", 32'(wr_drop), 32'h1);
    edge_step();
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check_model();
    chk("drop_clr", 32'(wr_drop), 32'h0);
    edge_step();

    // Reset at cnt=20 restarts the full clear.
    for (int k = 0; k < 19; k++) cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    count_clear(n);
    chk("restart_len", 32'(n), 32'd32);

    // Small configuration: 3 ports, 8 registers, 16-bit data.
    @(negedge clk);
    s_rst = 1'b0;
    #1;
    chk("s_busy_start", 32'(s_busy), 32'h1);
    chk("s_drop_start", 32'(s_wr_drop), 32'h0);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      if (!s_busy) break;
      n++;
      @(negedge clk);
      #1;
    end
    chk("s_clear_len", 32'(n), 32'd8);
    @(negedge clk); s_we = 1'b1; s_waddr = 3'd1; s_wdata = 16'h0001;
    @(negedge clk); s_waddr = 3'd2; s_wdata = 16'h0002;
    @(negedge clk); s_waddr = 3'd6; s_wdata = 16'h0006;
    @(negedge clk); s_we = 1'b0; s_raddr = {3'd6, 3'd2, 3'd1};
    #1;
    chk("s_rd_p0", 32'(s_rdata[15:0]), 32'h0001);
    chk("s_rd_p1", 32'(s_rdata[31:16]), 32'h0002);
    chk("s_rd_p2", 32'(s_rdata[47:32]), 32'h0006);
    @(negedge clk); s_raddr = {3'd2, 3'd2, 3'd2};
    #1;
    chk("s_same_p0", 32'(s_rdata[15:0]), 32'h0002);
    chk("s_same_p2", 32'(s_rdata[47:32]), 32'h0002);
    @(negedge clk); s_raddr = {3'd0, 3'd7, 3'd0};
    #1;
    chk("s_zero_p0", 32'(s_rdata[15:0]), 32'h0);
    chk("s_zero_p1", 32'(s_rdata[31:16]), 32'h0);
    chk("s_drop_end", 32'(s_wr_drop), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
